// File: rtl/constraint_enforcer.sv
// Constraint stage: sweeps nodes, clamps each to the previous node's enforced position and the box, writes it back.
// Optional pinned node 0 via `CONSTRAINT_PIN_EN.
module constraint_enforcer #(
    parameter int unsigned  NODES    = 5,
    parameter logic [31:0]  MAX_LINK = 32'h0001_0000,
    parameter logic [31:0]  BOX_MIN  = 32'hFFF6_0000,
    parameter logic [31:0]  BOX_MAX  = 32'h000A_0000,
    localparam int unsigned IW       = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IW-1:0]    rd_idx,
    input  logic [31:0]      rd_x,
    input  logic [31:0]      rd_y,
    output logic             wr_en,
    output logic [IW-1:0]    wr_idx,
    output logic [31:0]      wr_x,
    output logic [31:0]      wr_y,
    output logic [NODES-1:0] fix_state,
    output logic             busy,
    output logic             done
`ifdef CONSTRAINT_PIN_EN
    ,
    input  logic [31:0]      pin_x,
    input  logic [31:0]      pin_y
`endif
);

    localparam logic signed [32:0] LINK_HI = $signed({MAX_LINK[31], MAX_LINK});
    localparam logic signed [32:0] LINK_LO = -LINK_HI;
    localparam logic signed [31:0] BOX_LO  = $signed(BOX_MIN);
    localparam logic signed [31:0] BOX_HI  = $signed(BOX_MAX);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_WRITE, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_idx;
    logic [31:0]    r_raw_x, r_raw_y, r_res_x, r_res_y, r_prev_x, r_prev_y;
    logic [31:0]    w_enf_x, w_enf_y;
    logic           w_last, w_idx_clr, w_idx_inc, w_load_raw, w_calc, w_write;
    logic           w_busy_nxt, w_done_nxt;

    // Link clamp (difference taken at 33 bits so it cannot wrap), then box clamp.
    function automatic logic [31:0] enforce_axis(input logic [31:0] raw,
                                                 input logic [31:0] prev,
                                                 input logic        skip_link);
        logic signed [32:0] d;
        logic signed [31:0] v;
        d = $signed({raw[31], raw}) - $signed({prev[31], prev});
        v = $signed(raw);
        if (!skip_link) begin
            if (d > LINK_HI)
                v = $signed(prev + MAX_LINK);
            else if (d < LINK_LO)
                v = $signed(prev - MAX_LINK);
        end
        if (v < BOX_LO)
            v = BOX_LO;
        else if (v > BOX_HI)
            v = BOX_HI;
        return 32'(v);
    endfunction

    assign w_last = (r_idx == IW'(NODES - 1));

`ifdef CONSTRAINT_PIN_EN
    assign w_enf_x = (r_idx == '0) ? pin_x : enforce_axis(r_raw_x, r_prev_x, 1'b0);
    assign w_enf_y = (r_idx == '0) ? pin_y : enforce_axis(r_raw_y, r_prev_y, 1'b0);
`else
    assign w_enf_x = enforce_axis(r_raw_x, r_prev_x, r_idx == '0);
    assign w_enf_y = enforce_axis(r_raw_y, r_prev_y, r_idx == '0);
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_idx_clr  = 1'b0;
        w_idx_inc  = 1'b0;
        w_load_raw = 1'b0;
        w_calc     = 1'b0;
        w_write    = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE:  w_idx_clr  = start;
            S_FETCH: w_load_raw = 1'b1;
            S_CALC:  w_calc     = 1'b1;
            S_WRITE: begin
                w_write   = 1'b1;
                w_idx_inc = !w_last;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_CALC) ||
                     (w_state_nxt == S_WRITE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx     <= '0;
            rd_idx    <= '0;
            r_raw_x   <= '0;
            r_raw_y   <= '0;
            r_res_x   <= '0;
            r_res_y   <= '0;
            r_prev_x  <= '0;
            r_prev_y  <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            wr_x      <= '0;
            wr_y      <= '0;
            fix_state <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            wr_en     <= w_write;
            fix_state <= w_write ? (NODES'(1) << r_idx) : '0;
            if (w_idx_clr) begin
                r_idx  <= '0;
                rd_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx  <= r_idx + IW'(1);
                rd_idx <= r_idx + IW'(1);
            end
            if (w_load_raw) begin
                r_raw_x <= rd_x;
                r_raw_y <= rd_y;
            end
            if (w_calc) begin
                r_res_x <= w_enf_x;
                r_res_y <= w_enf_y;
            end
            if (w_write) begin
                wr_idx   <= r_idx;
                wr_x     <= r_res_x;
                wr_y     <= r_res_y;
                r_prev_x <= r_res_x;
                r_prev_y <= r_res_y;
            end
        end
    end

endmodule

// File: tb/tb_constraint_enforcer.sv
// Bench for constraint_enforcer: directed and random sweeps against an arithmetic reference model.
// Build with +define+CONSTRAINT_PIN_EN to exercise the pinned-node variant.
module tb_constraint_enforcer;

    localparam int unsigned N  = 5;
    localparam int unsigned IW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [IW-1:0]   rd_idx;
    logic [31:0]     rd_x, rd_y;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [31:0]     wr_x, wr_y;
    logic [N-1:0]    fix_state;
    logic            busy, done;
    logic [31:0]     pin_x, pin_y;

    logic [31:0]     raw_x [N];
    logic [31:0]     raw_y [N];
    logic [31:0]     ex [N];
    logic [31:0]     ey [N];
    logic [31:0]     last_x, last_y, last_idx;

    int vectors    = 0;
    int miscompares = 0;

    assign rd_x = (rd_idx < IW'(N)) ? raw_x[rd_idx] : 32'h0;
    assign rd_y = (rd_idx < IW'(N)) ? raw_y[rd_idx] : 32'h0;

    constraint_enforcer dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .fix_state(fix_state), .busy(busy), .done(done)
`ifdef CONSTRAINT_PIN_EN
        , .pin_x(pin_x), .pin_y(pin_y)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Plain-integer model of one axis: link limit of 1.0, box of +/-10.0.
    function automatic logic [31:0] model_axis(input logic [31:0] raw, input logic [31:0] prev,
                                               input bit first);
        longint r, p, v;
        r = longint'($signed(raw));
        p = longint'($signed(prev));
        v = r;
        if (!first) begin
            if (r - p > 65536)       v = p + 65536;
            else if (r - p < -65536) v = p - 65536;
        end
        if (v < -655360) v = -655360;
        if (v > 655360)  v = 655360;
        return v[31:0];
    endfunction

    task automatic build_exp();
        for (int k = 0; k < N; k++) begin
`ifdef CONSTRAINT_PIN_EN
            if (k == 0) begin
                ex[k] = pin_x;
                ey[k] = pin_y;
                continue;
            end
`endif
            ex[k] = model_axis(raw_x[k], (k == 0) ? 32'h0 : ex[(k == 0) ? 0 : k - 1], k == 0);
            ey[k] = model_axis(raw_y[k], (k == 0) ? 32'h0 : ey[(k == 0) ? 0 : k - 1], k == 0);
        end
    endtask

    function automatic logic [31:0] rnd();
        int unsigned sel;
        logic [31:0] edges [4];
        edges[0] = 32'h000A_0000; edges[1] = 32'hFFF6_0000;
        edges[2] = 32'h8000_0000; edges[3] = 32'h7FFF_FFFF;
        sel = $urandom_range(0, 4);
        if (sel == 0) return $urandom;
        if (sel == 1) return edges[$urandom_range(0, 3)];
        return 32'($urandom_range(0, 1572864)) - 32'd786432;
    endfunction

    task automatic randomize_raw();
        for (int k = 0; k < N; k++) begin
            raw_x[k] = rnd();
            raw_y[k] = rnd();
        end
    endtask

    // Present start for one edge (edge 0 of the sweep); optionally leave it high.
    task automatic kick(input bit keep);
        build_exp();
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
    endtask

    // Cycle-by-cycle check of edges 1..ncyc after the start edge.
    task automatic check_sweep(input int ncyc, input bit poke);
        int k;
        bit we;
        for (int c = 1; c <= ncyc; c++) begin
            if (poke) start = (c == 5 || c == 3 * N + 1);
            @(posedge clk); #1;
            we = (c % 3 == 0) && (c >= 3) && (c <= 3 * N);
            k  = c / 3 - 1;
            check("wr_en", 32'(wr_en), 32'(we));
            if (we) begin
                last_x = ex[k]; last_y = ey[k]; last_idx = k;
            end
            check("fix_state", 32'(fix_state), we ? (32'h1 << k) : 32'h0);
            check("wr_x", wr_x, last_x);
            check("wr_y", wr_y, last_y);
            check("wr_idx", 32'(wr_idx), last_idx);
            check("busy", 32'(busy), 32'(c < 3 * N));
            check("done", 32'(done), 32'(c == 3 * N + 1));
            check("rd_idx", 32'(rd_idx), (c / 3 < N) ? 32'(c / 3) : 32'(N - 1));
        end
        if (poke) start = 1'b0;
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_wr_en", 32'(wr_en), 32'h0);
            check("idle_done", 32'(done), 32'h0);
        end
    endtask

    task automatic full_sweep(input bit poke);
        kick(1'b0);
        check_sweep(3 * N + 1, poke);
        check_idle(2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pin_x = '0; pin_y = '0;
        last_x = '0; last_y = '0; last_idx = '0;
        for (int k = 0; k < N; k++) begin raw_x[k] = '0; raw_y[k] = '0; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_fix", 32'(fix_state), 32'h0);
        check("rst_wr_x", wr_x, 32'h0);
        check("rst_wr_y", wr_y, 32'h0);
        check("rst_rd_idx", 32'(rd_idx), 32'h0);
        check("rst_wr_idx", 32'(wr_idx), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // All-zero sweep.
        full_sweep(1'b0);

        // Link clamp chain.
        raw_x[0] = 32'h0; raw_x[1] = 32'h0003_0000; raw_x[2] = 32'h0003_0000;
        raw_x[3] = 32'h0; raw_x[4] = 32'hFFFB_0000;
        full_sweep(1'b0);

        // Differences exactly at +/-1.0 pass unchanged.
        raw_x[0] = 32'h0; raw_x[1] = 32'h0001_0000; raw_x[2] = 32'h0002_0000;
        raw_x[3] = 32'h0001_0000; raw_x[4] = 32'h0;
        raw_y[0] = 32'h0; raw_y[1] = 32'hFFFF_0000; raw_y[2] = 32'hFFFE_0000;
        raw_y[3] = 32'hFFFF_0000; raw_y[4] = 32'h0;
        full_sweep(1'b0);

        // Box clamp on node 0, then the extreme codes.
        randomize_raw(); raw_y[0] = 32'h0014_0000; full_sweep(1'b0);
        randomize_raw(); raw_x[0] = 32'h8000_0000; full_sweep(1'b0);
        randomize_raw(); raw_x[0] = 32'h000A_0000; full_sweep(1'b0);
        randomize_raw(); raw_x[0] = 32'h7FFF_FFFF; raw_y[0] = 32'hFFF6_0000; full_sweep(1'b0);

        // start pulsed while busy and while in DONE is ignored.
        randomize_raw();
        full_sweep(1'b1);

        // start held high: back-to-back sweeps.
        randomize_raw();
        kick(1'b1);
        check_sweep(3 * N + 1, 1'b0);
        @(posedge clk); #1;
        check("hold_busy", 32'(busy), 32'h1);
        check("hold_rd_idx", 32'(rd_idx), 32'h0);
        start = 1'b0;
        check_sweep(3 * N + 1, 1'b0);
        check_idle(2);

        // Reset during node-2 WRITE aborts without done.
        randomize_raw();
        kick(1'b0);
        check_sweep(8, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_x = '0; last_y = '0; last_idx = '0;
        check("abort_wr_en", 32'(wr_en), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_fix", 32'(fix_state), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_rd_idx", 32'(rd_idx), 32'h0);
        check_idle(4);
        randomize_raw();
        full_sweep(1'b0);

`ifdef CONSTRAINT_PIN_EN
        // Pinned node 0 overrides raw data; node 1 links to the pin.
        pin_x = 32'h0002_0000; pin_y = 32'h0;
        randomize_raw();
        raw_x[0] = 32'h0005_0000; raw_y[0] = 32'h0;
        raw_x[1] = 32'h0; raw_y[1] = 32'h0;
        full_sweep(1'b0);
        pin_x = 32'hFFF0_0000; pin_y = 32'h7FFF_0000;
        randomize_raw();
        full_sweep(1'b0);
`endif

        // Random sweeps.
        for (int s = 0; s < 8; s++) begin
`ifdef CONSTRAINT_PIN_EN
            pin_x = rnd(); pin_y = rnd();
`endif
            randomize_raw();
            full_sweep(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
